// File: rtl/jtcps_snd_mixer.sv
// jtcps_snd_mixer: time-multiplexed N-channel audio mixer with gain ramping, saturation and overrun flag
// Ports:
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   i_sample_in     : one-cycle strobe starting a new mix
//   i_ch_in         : signed channel samples, channel k at [k*W +: W]
//   i_gain          : unsigned 4.4 gains, channel k at [k*8 +: 8] (0x10 = 1.0)
//   i_ch_en         : per-channel enable
//   o_mixed         : signed saturated mix, held between updates
//   o_sample_out    : one-cycle strobe when o_mixed updates
//   o_peak          : pulses with o_sample_out when the mix saturated
//   o_overrun       : sticky, a strobe arrived while a mix was in progress
module jtcps_snd_mixer #(
   parameter int CH   = 4,
   parameter int W    = 16,
   parameter int WOUT = 16,
   parameter int RAMP = 2
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_sample_in,
   input  logic [CH*W-1:0]        i_ch_in,
   input  logic [CH*8-1:0]        i_gain,
   input  logic [CH-1:0]          i_ch_en,
   output logic signed [WOUT-1:0] o_mixed,
   output logic                   o_sample_out,
   output logic                   o_peak,
   output logic                   o_overrun
);
   localparam int KW = $clog2(CH);
   localparam int AW = W + 9 + KW;
   localparam logic signed [AW-1:0] MAXV = {{(AW-WOUT+1){1'b0}}, {(WOUT-1){1'b1}}};
   localparam logic signed [AW-1:0] MINV = {{(AW-WOUT+1){1'b1}}, {(WOUT-1){1'b0}}};
   localparam logic [8:0] RSTEP = 9'(RAMP);
   typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
   state_t r_state, w_next;
   logic [KW-1:0]         r_k;
   logic [CH*W-1:0]       r_ch;
   logic [CH*8-1:0]       r_gain;
   logic [CH-1:0]         r_en;
   logic [7:0]            r_cur [CH];
   logic signed [AW-1:0]  r_acc;
   logic signed [W-1:0]   w_x;
   logic [7:0]            w_g, w_t, w_ng;
   logic [8:0]            w_up, w_dn;
   logic signed [W+8:0]   w_prod;
   logic signed [AW-1:0]  w_acc_n, w_sh;
   logic                  w_last, w_hi, w_lo;
   assign w_last  = (r_k == KW'(CH-1));
   assign w_x     = r_ch[r_k*W +: W];
   assign w_g     = r_cur[r_k];
   assign w_t     = r_en[r_k] ? r_gain[r_k*8 +: 8] : 8'd0;
   // gain is unsigned 4.4, zero-extended so the multiply stays signed
   assign w_prod  = w_x * $signed({1'b0, w_g});
   assign w_acc_n = r_acc + {{(AW-W-9){w_prod[W+8]}}, w_prod};
   assign w_up    = {1'b0, w_t} - {1'b0, w_g};
   assign w_dn    = {1'b0, w_g} - {1'b0, w_t};
   // steps of RAMP toward the target, landing exactly on it when closer than one step
   assign w_ng    = (RAMP == 0) ? w_t :
                    (w_g < w_t) ? ((w_up > RSTEP) ? w_g + 8'(RAMP) : w_t) :
                    (w_g > w_t) ? ((w_dn > RSTEP) ? w_g - 8'(RAMP) : w_t) : w_t;
   assign w_sh    = r_acc >>> 4;
   assign w_hi    = w_sh > MAXV;
   assign w_lo    = w_sh < MINV;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_next;
   always_comb begin
      w_next = r_state;
      if (r_state == IDLE && i_sample_in) w_next = ACC;
      else if (r_state == ACC && w_last)  w_next = OUT;
      else if (r_state == OUT)            w_next = IDLE;
   end
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         o_mixed      <= '0;
         o_sample_out <= 1'b0;
         o_peak       <= 1'b0;
         o_overrun    <= 1'b0;
         r_k          <= '0;
         r_ch         <= '0;
         r_gain       <= '0;
         r_en         <= '0;
         r_acc        <= '0;
         for (int i = 0; i < CH; i++) r_cur[i] <= '0;
      end else begin
         o_sample_out <= (r_state == OUT);
         o_peak       <= (r_state == OUT) && (w_hi || w_lo);
         if (i_sample_in && r_state != IDLE) o_overrun <= 1'b1;
         if (r_state == IDLE && i_sample_in) begin
            r_ch   <= i_ch_in;
            r_gain <= i_gain;
            r_en   <= i_ch_en;
            r_acc  <= '0;
            r_k    <= '0;
         end
         if (r_state == ACC) begin
            r_acc      <= w_acc_n;
            r_cur[r_k] <= w_ng;
            r_k        <= r_k + KW'(1);
         end
         if (r_state == OUT)
            o_mixed <= w_hi ? {1'b0, {(WOUT-1){1'b1}}} :
                       w_lo ? {1'b1, {(WOUT-1){1'b0}}} : w_sh[WOUT-1:0];
      end
endmodule
